trng_ro_sampler_pp: RTL and testbench



---
 rtl/trng_ro_sampler_pp_if.sv | 24 ++
 rtl/trng_ro_sampler_pp.sv | 224 ++++++++++++++++++++++
 tb/tb_trng_ro_sampler_pp.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_ro_sampler_pp_if.sv
// Output handshake bundle for the TRNG sampler back end.
//   rdata_o  : packed random word, driven by the producer
//   rvalid_o : rdata_o holds an unconsumed word
//   rready_i : consumer accepts the word on this edge
// The sampler uses the master modport; the register block uses slave.
interface trng_ro_sampler_pp_if #(
    parameter int unsigned OUT_W = 32
);
    logic [OUT_W-1:0] rdata_o;
    logic             rvalid_o;
    logic             rready_i;

    modport master (
        output rdata_o,
        output rvalid_o,
        input  rready_i
    );

    modport slave (
        input  rdata_o,
        input  rvalid_o,
        output rready_i
    );
endinterface

// File: rtl/trng_ro_sampler_pp.sv
// Ring-oscillator TRNG sampling and post-processing back end.
// Samples N_CH free-running RO outputs and XOR-folds them to one bit per
// cycle. The bit stream is then decimated, checked by a repetition-count
// health test, optionally von Neumann debiased, and packed LSB first into
// OUT_W-bit words.
// Ports:
//   clk, rst_i    : clock, asynchronous active-high reset
//   en_i          : sampling enable (in-flight bits still drain when low)
//   ro_bits_i     : asynchronous RO outputs
//   dec_i         : dec_i+1 raw bits are XOR-folded into one output bit
//   vn_en_i       : von Neumann debias enable
//   rct_cutoff_i  : repetition-count cutoff, 0 disables the test
//   clr_alarm_i   : clears the sticky alarm and the repetition counter
//   rd            : rdata_o / rvalid_o / rready_i word handshake
//   alarm_o       : sticky health-test failure
module trng_ro_sampler_pp #(
    parameter int unsigned N_CH  = 32,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned DEC_W = 8,
    parameter int unsigned RCT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [N_CH-1:0]      ro_bits_i,
    input  logic [DEC_W-1:0]     dec_i,
    input  logic                 vn_en_i,
    input  logic [RCT_W-1:0]     rct_cutoff_i,
    input  logic                 clr_alarm_i,
    trng_ro_sampler_pp_if.master rd,
    output logic                 alarm_o
);

    localparam int unsigned PCNT_W = (OUT_W > 2) ? $clog2(OUT_W) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(OUT_W - 1);

    // S1 / S2: capture and fold channels
    logic [N_CH-1:0]  s1;
    logic             v1;
    logic             x;
    logic             v2;

    // S3: decimation
    logic             acc;
    logic [DEC_W-1:0] dcnt;
    logic             dbit;
    logic             v3;

    // S4: health test and debias
    logic [RCT_W-1:0] rct_cnt;
    logic [RCT_W-1:0] rct_cnt_nxt;
    logic             rct_last;
    logic             rct_last_nxt;
    logic             alarm_set;

    logic             vn_q;
    logic             vn_flip;
    logic             hold_v;
    logic             hold_b;
    logic             hold_v_nxt;
    logic             hold_b_nxt;
    logic             vn_out_v;
    logic             vn_out_b;

    // Packer and output register
    logic [OUT_W-2:0]  word_q;
    logic [PCNT_W-1:0] pcnt;
    logic [OUT_W-1:0]  rdata_q;
    logic              rvalid_q;
    logic              pack_v;
    logic              word_done;
    logic              out_free;
    logic              load;

    assign rd.rdata_o  = rdata_q;
    assign rd.rvalid_o = rvalid_q;

    // ------------------------------------------------------------------
    // S1: sample RO bank. S2: parity of the sampled channels.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            s1 <= '0;
            v1 <= 1'b0;
            x  <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (en_i) begin
                s1 <= ro_bits_i;
            end
            v1 <= en_i;
            x  <= ^s1;
            v2 <= v1;
        end
    end

    // ------------------------------------------------------------------
    // S3: fold dec_i+1 valid bits into one. dec_i is compared live, so a
    // lowered setting flushes the partial fold on the next valid bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            acc  <= 1'b0;
            dcnt <= '0;
            dbit <= 1'b0;
            v3   <= 1'b0;
        end else begin
            v3 <= 1'b0;
            if (v2) begin
                if (dcnt >= dec_i) begin
                    dbit <= acc ^ x;
                    v3   <= 1'b1;
                    acc  <= 1'b0;
                    dcnt <= '0;
                end else begin
                    acc  <= acc ^ x;
                    dcnt <= dcnt + DEC_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S4 repetition-count test. rct_cnt==0 marks "no reference bit yet".
    // ------------------------------------------------------------------
    always_comb begin
        rct_cnt_nxt  = rct_cnt;
        rct_last_nxt = rct_last;
        alarm_set    = 1'b0;
        if (v3) begin
            if (rct_cnt == '0 || dbit != rct_last) begin
                rct_last_nxt = dbit;
                rct_cnt_nxt  = RCT_W'(1);
            end else if (rct_cnt != '1) begin
                rct_cnt_nxt = rct_cnt + RCT_W'(1);
            end
            alarm_set = (rct_cutoff_i != '0) && (rct_cnt_nxt >= rct_cutoff_i);
        end
    end

    // ------------------------------------------------------------------
    // S4 von Neumann. The mode in force is the registered vn_q; an edge
    // where vn_en_i differs from it drops the held half-pair and, in VN
    // mode, the bit arriving with it, so no pair straddles a mode change.
    // ------------------------------------------------------------------
    assign vn_flip = (vn_en_i != vn_q);

    always_comb begin
        hold_v_nxt = hold_v;
        hold_b_nxt = hold_b;
        vn_out_v   = 1'b0;
        vn_out_b   = dbit;
        if (v3) begin
            if (!vn_q) begin
                vn_out_v = 1'b1;
            end else if (!vn_flip) begin
                if (!hold_v) begin
                    hold_v_nxt = 1'b1;
                    hold_b_nxt = dbit;
                end else begin
                    hold_v_nxt = 1'b0;
                    vn_out_v   = (hold_b != dbit);
                    vn_out_b   = hold_b;
                end
            end
        end
        if (vn_flip) begin
            hold_v_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rct_cnt  <= '0;
            rct_last <= 1'b0;
            alarm_o  <= 1'b0;
            vn_q     <= 1'b0;
            hold_v   <= 1'b0;
            hold_b   <= 1'b0;
        end else begin
            rct_last <= rct_last_nxt;
            rct_cnt  <= clr_alarm_i ? '0 : rct_cnt_nxt;
            // A trigger on the clearing edge keeps the alarm raised.
            if (alarm_set) begin
                alarm_o <= 1'b1;
            end else if (clr_alarm_i) begin
                alarm_o <= 1'b0;
            end
            vn_q   <= vn_en_i;
            hold_v <= hold_v_nxt;
            hold_b <= hold_b_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Packer. Packing is gated by the alarm as it stood before this edge.
    // With the output register occupied, the completing bit is dropped
    // and pcnt parks on the last position until the consumer frees it.
    // ------------------------------------------------------------------
    assign pack_v    = vn_out_v && !alarm_o;
    assign word_done = pack_v && (pcnt == PCNT_LAST);
    assign out_free  = !rvalid_q || rd.rready_i;
    assign load      = word_done && out_free;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            word_q   <= '0;
            pcnt     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (pack_v && pcnt != PCNT_LAST) begin
                word_q[pcnt] <= vn_out_b;
                pcnt         <= pcnt + PCNT_W'(1);
            end
            if (load) begin
                rdata_q <= {vn_out_b, word_q};
                pcnt    <= '0;
            end
            rvalid_q <= load || (rvalid_q && !rd.rready_i);
        end
    end

endmodule

// File: tb/tb_trng_ro_sampler_pp.sv
// Self-checking bench for trng_ro_sampler_pp (N_CH=4, OUT_W=8).
// A bit-stream reference model (fold list, pair holder, run length, bit
// queue for the packer) predicts rdata_o, rvalid_o and alarm_o each cycle.
module tb_trng_ro_sampler_pp;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned DEC_W = 8;
    localparam int unsigned RCT_W = 8;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             en;
    logic [N_CH-1:0]  ro;
    logic [DEC_W-1:0] dec;
    logic             vn;
    logic [RCT_W-1:0] cutoff;
    logic             clr;
    logic             rready;
    logic             alarm;

    trng_ro_sampler_pp_if #(.OUT_W(OUT_W)) rd_if ();
    assign rd_if.rready_i = rready;

    trng_ro_sampler_pp #(
        .N_CH (N_CH),
        .OUT_W(OUT_W),
        .DEC_W(DEC_W),
        .RCT_W(RCT_W)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .en_i        (en),
        .ro_bits_i   (ro),
        .dec_i       (dec),
        .vn_en_i     (vn),
        .rct_cutoff_i(cutoff),
        .clr_alarm_i (clr),
        .rd          (rd_if),
        .alarm_o     (alarm)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          h_v[2];        // samples taken one and two edges ago
    bit          h_p[2];
    bit          fold_q[$];     // raw bits waiting to be folded
    bit          pend_v, pend_b; // folded bit reaching the health/debias stage next edge
    int unsigned run_len;
    bit          run_last;
    bit          m_alarm;
    bit          held_v, held_b;
    bit          vn_prev;
    bit          pk_q[$];       // bits of the word being assembled
    logic [OUT_W-1:0] m_rdata;
    bit          m_rvalid;

    task automatic model_reset();
        h_v = '{0, 0};
        h_p = '{0, 0};
        fold_q.delete();
        pend_v = 0; pend_b = 0;
        run_len = 0; run_last = 0;
        m_alarm = 0;
        held_v = 0; held_b = 0; vn_prev = 0;
        pk_q.delete();
        m_rdata = '0;
        m_rvalid = 0;
    endtask

    task automatic model_edge();
        bit xv, xb, emit_v, emit_b, out_v, out_b, set_a, vn_chg, loaded;
        xv = h_v[1];
        xb = h_p[1];
        h_v[1] = h_v[0]; h_p[1] = h_p[0];
        h_v[0] = en;     h_p[0] = ^ro;

        emit_v = 0; emit_b = 0;
        if (xv) begin
            if (fold_q.size() >= int'(dec)) begin
                emit_b = xb;
                foreach (fold_q[i]) emit_b ^= fold_q[i];
                fold_q.delete();
                emit_v = 1;
            end else begin
                fold_q.push_back(xb);
            end
        end

        set_a = 0; out_v = 0; out_b = 0;
        vn_chg = (vn != vn_prev);
        if (pend_v) begin
            if (run_len == 0 || pend_b != run_last) begin
                run_last = pend_b;
                run_len  = 1;
            end else if (run_len < 255) begin
                run_len++;
            end
            set_a = (cutoff != 0) && (run_len >= int'(cutoff));
            if (!vn_prev) begin
                out_v = 1; out_b = pend_b;
            end else if (!vn_chg) begin
                if (!held_v) begin
                    held_v = 1; held_b = pend_b;
                end else begin
                    held_v = 0;
                    if (held_b != pend_b) begin
                        out_v = 1; out_b = held_b;
                    end
                end
            end
        end
        if (vn_chg) held_v = 0;
        vn_prev = vn;

        loaded = 0;
        if (out_v && !m_alarm) begin
            if (pk_q.size() == OUT_W - 1) begin
                if (!m_rvalid || rready) begin
                    for (int i = 0; i < OUT_W - 1; i++) m_rdata[i] = pk_q[i];
                    m_rdata[OUT_W-1] = out_b;
                    pk_q.delete();
                    loaded = 1;
                end
            end else begin
                pk_q.push_back(out_b);
            end
        end
        m_rvalid = loaded ? 1'b1 : (rready ? 1'b0 : m_rvalid);

        if (set_a) m_alarm = 1;
        else if (clr) m_alarm = 0;
        if (clr) run_len = 0;

        pend_v = emit_v;
        pend_b = emit_b;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("rvalid", rd_if.rvalid_o, m_rvalid);
        check("rdata", rd_if.rdata_o, m_rdata);
        check("alarm", alarm, m_alarm);
    endtask

    // Constant single-channel-high input: expects the first word after E11.
    task automatic run_first_word(input string tag);
        int unsigned edges;
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (rd_if.rvalid_o) begin
                edges = i;
                break;
            end
        end
        check({tag, "_latency"}, edges, 11);
        check({tag, "_word"}, rd_if.rdata_o, 8'hFF);
        repeat (17) step();
    endtask

    task automatic set_s1_inputs();
        en = 1; ro = 4'b0001; dec = 0; vn = 0; cutoff = 0; clr = 0; rready = 1;
    endtask

    initial begin
        int unsigned n;
        int unsigned ro_mode, en_pct, rdy_pct;
        logic [N_CH-1:0] ro_const;

        rst_i = 1;
        en = 0; ro = '0; dec = '0; vn = 0; cutoff = '0; clr = 0; rready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid", rd_if.rvalid_o, 0);
        check("rst_rdata", rd_if.rdata_o, 0);
        check("rst_alarm", alarm, 0);

        // first word timing, then steady one word every OUT_W cycles
        set_s1_inputs();
        rst_i = 0;
        model_reset();
        run_first_word("s1");

        // repetition-count alarm on constant stream
        clr = 1; step(); clr = 0;
        cutoff = 5;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (alarm) begin
                n = i;
                break;
            end
        end
        check("rct_edges", n, 5);
        repeat (6) step();
        en = 0;
        repeat (4) step();
        clr = 1; step(); clr = 0;
        check("rct_clr_alone", alarm, 0);
        en = 1;
        repeat (10) step();
        clr = 1; step(); clr = 0;
        check("rct_clr_vs_set", alarm, 1);
        cutoff = 0;
        clr = 1; step(); clr = 0;

        // randomized phases
        for (int ph = 0; ph < 14; ph++) begin
            dec      = DEC_W'($urandom_range(0, 3));
            vn       = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: cutoff = 0;
                1: cutoff = 4;
                2: cutoff = 7;
                default: cutoff = 12;
            endcase
            ro_mode  = $urandom_range(0, 2);
            ro_const = N_CH'($urandom);
            en_pct   = $urandom_range(50, 100);
            rdy_pct  = $urandom_range(5, 100);
            for (int c = 0; c < 350; c++) begin
                case (ro_mode)
                    0: ro = N_CH'($urandom);
                    1: ro = ro_const;
                    default: ro = ($urandom_range(0, 9) == 0) ? N_CH'($urandom) : ro_const;
                endcase
                en     = ($urandom_range(1, 100) <= en_pct);
                rready = ($urandom_range(1, 100) <= rdy_pct);
                clr    = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 29) == 0) dec = DEC_W'($urandom_range(0, 3));
                if ($urandom_range(0, 39) == 0) vn = ~vn;
                step();
            end
        end

        // asynchronous reset with a word pending and a partial word in flight
        en = 1; ro = N_CH'($urandom); dec = 0; vn = 0; cutoff = 0; rready = 0;
        clr = 1; step(); clr = 0;
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            ro = N_CH'($urandom);
            step();
            if (rd_if.rvalid_o) begin
                n = i;
                break;
            end
        end
        check("pre_rst_valid", (n != 0), 1);
        repeat (3) step();
        #2;
        rst_i = 1;
        #1;
        check("async_rvalid", rd_if.rvalid_o, 0);
        check("async_rdata", rd_if.rdata_o, 0);
        check("async_alarm", alarm, 0);
        @(posedge clk);
        @(negedge clk);
        set_s1_inputs();
        rst_i = 0;
        model_reset();
        run_first_word("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
